// File: rtl/ct_mmu_dutlb_huge_ctrl_pkg.sv
// Shared MMU constants and refill FSM encoding for the data-side huge-page uTLB.
package ct_mmu_dutlb_huge_ctrl_pkg;

  localparam int ENTRY_NUM_DFLT = 4;
  localparam int VPN_WIDTH      = 27;
  localparam int LVL_WIDTH      = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10
  } refill_state_e;

endpackage

// File: rtl/ct_mmu_dutlb_huge_ctrl_if.sv
// Refill channel between the huge-page uTLB controller (master) and the jTLB (slave).
interface ct_mmu_dutlb_huge_ctrl_if
  import ct_mmu_dutlb_huge_ctrl_pkg::*;
();

  logic                 utlb_jtlb_req;
  logic [VPN_WIDTH-1:0] utlb_jtlb_vpn;
  logic                 jtlb_utlb_ack;
  logic                 jtlb_utlb_resp_vld;
  logic                 jtlb_utlb_resp_huge;
  logic                 jtlb_utlb_resp_fault;

  modport master (
    output utlb_jtlb_req, utlb_jtlb_vpn,
    input  jtlb_utlb_ack, jtlb_utlb_resp_vld, jtlb_utlb_resp_huge, jtlb_utlb_resp_fault
  );

  modport slave (
    input  utlb_jtlb_req, utlb_jtlb_vpn,
    output jtlb_utlb_ack, jtlb_utlb_resp_vld, jtlb_utlb_resp_huge, jtlb_utlb_resp_fault
  );

endinterface

// File: rtl/ct_mmu_dutlb_huge_repl.sv
// Victim selection state for the huge uTLB: tree pseudo-LRU when
// CT_MMU_DUTLB_HUGE_PLRU_EN is defined, otherwise a round-robin pointer.
module ct_mmu_dutlb_huge_repl
  import ct_mmu_dutlb_huge_ctrl_pkg::*;
#(
  parameter  int ENTRY_NUM = ENTRY_NUM_DFLT,
  localparam int IDX_W     = $clog2(ENTRY_NUM)
) (
  input  logic                 utlb_entry_clk,
  input  logic                 cpurst_b,
  input  logic                 repl_clr,
  input  logic [ENTRY_NUM-1:0] touch0,
  input  logic [ENTRY_NUM-1:0] touch1,
  input  logic [ENTRY_NUM-1:0] touch_upd,
  output logic [IDX_W-1:0]     victim_idx
);

`ifdef CT_MMU_DUTLB_HUGE_PLRU_EN

  // Heap-ordered tree: node bit 1 steers the victim walk toward the upper half.
  logic [ENTRY_NUM-2:0] plru_q;
  logic [ENTRY_NUM-2:0] plru_d;

  function automatic logic [IDX_W-1:0] oh2idx(input logic [ENTRY_NUM-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < ENTRY_NUM; i++)
      if (oh[i]) idx = IDX_W'(i);
    return idx;
  endfunction

  function automatic logic [ENTRY_NUM-2:0] plru_touch(input logic [ENTRY_NUM-2:0] t,
                                                       input logic [IDX_W-1:0]     idx);
    logic [ENTRY_NUM-2:0] r;
    r = t;
    for (int l = 0; l < IDX_W; l++)
      for (int k = 0; k < (1 << l); k++)
        if (int'(idx >> (IDX_W - l)) == k) r[(1 << l) - 1 + k] = ~idx[IDX_W-1-l];
    return r;
  endfunction

  function automatic logic [IDX_W-1:0] plru_victim(input logic [ENTRY_NUM-2:0] t);
    logic [IDX_W-1:0] v;
    v = '0;
    for (int l = 0; l < IDX_W; l++)
      for (int k = 0; k < (1 << l); k++)
        if (int'(v >> (IDX_W - l)) == k) v[IDX_W-1-l] = t[(1 << l) - 1 + k];
    return v;
  endfunction

  // Touch order within one cycle: port 0 hit, port 1 hit, then the fill.
  always_comb begin
    plru_d = plru_q;
    if (|touch0)    plru_d = plru_touch(plru_d, oh2idx(touch0));
    if (|touch1)    plru_d = plru_touch(plru_d, oh2idx(touch1));
    if (|touch_upd) plru_d = plru_touch(plru_d, oh2idx(touch_upd));
  end

  always_ff @(posedge utlb_entry_clk or negedge cpurst_b) begin
    if (!cpurst_b)     plru_q <= '0;
    else if (repl_clr) plru_q <= '0;
    else               plru_q <= plru_d;
  end

  assign victim_idx = plru_victim(plru_q);

`else

  logic [IDX_W-1:0] rr_ptr_q;
  logic             unused_touch;

  // Hits never age a round-robin pointer; only fills advance it.
  assign unused_touch = ^{touch0, touch1};

  always_ff @(posedge utlb_entry_clk or negedge cpurst_b) begin
    if (!cpurst_b)       rr_ptr_q <= '0;
    else if (repl_clr)   rr_ptr_q <= '0;
    else if (|touch_upd) rr_ptr_q <= rr_ptr_q + 1'b1;
  end

  assign victim_idx = rr_ptr_q;

`endif

endmodule

// File: rtl/ct_mmu_dutlb_huge_ctrl.sv
// Huge-page (level-2) data uTLB refill/replacement controller; replacement
// policy selected by CT_MMU_DUTLB_HUGE_PLRU_EN (PLRU) or round-robin by default.
module ct_mmu_dutlb_huge_ctrl
  import ct_mmu_dutlb_huge_ctrl_pkg::*;
#(
  parameter  int ENTRY_NUM = ENTRY_NUM_DFLT,
  localparam int IDX_W     = $clog2(ENTRY_NUM)
) (
  input  logic                   utlb_entry_clk,
  input  logic                   cpurst_b,
  input  logic                   lsu_req0_vld,
  input  logic                   lsu_req1_vld,
  input  logic [VPN_WIDTH-1:0]   utlb_req_vpn0,
  input  logic [VPN_WIDTH-1:0]   utlb_req_vpn1,
  input  logic [ENTRY_NUM-1:0]   entry_vld,
  input  logic [ENTRY_NUM-1:0]   entry_hit0,
  input  logic [ENTRY_NUM-1:0]   entry_hit1,
  input  logic                   regs_utlb_clr,
  input  logic                   tlboper_utlb_clr,
  input  logic                   tlboper_utlb_inv_va_req,
  ct_mmu_dutlb_huge_ctrl_if.master jtlb_if,
  output logic [ENTRY_NUM-1:0]   utlb_hit0_sel,
  output logic [ENTRY_NUM-1:0]   utlb_hit1_sel,
  output logic                   utlb_hit0,
  output logic                   utlb_hit1,
  output logic [ENTRY_NUM-1:0]   utlb_entry_upd,
  output logic                   utlb_refill_busy
);

  refill_state_e        state_q;
  refill_state_e        state_d;
  logic                 abort_q;
  logic [VPN_WIDTH-1:0] refill_vpn;
  logic [IDX_W-1:0]     refill_idx;
  logic [ENTRY_NUM-1:0] hit0_qual;
  logic [ENTRY_NUM-1:0] hit1_qual;
  logic                 miss0;
  logic                 miss1;
  logic                 any_miss;
  logic [VPN_WIDTH-1:0] miss_vpn;
  logic [IDX_W-1:0]     repl_victim;
  logic [IDX_W-1:0]     victim_idx;
  logic                 flush_now;
  logic                 repl_clr;
  logic                 refill_load;
  logic                 refill_req;
  logic                 refill_fill;

  // Lowest qualified index wins: isolate the least significant set bit.
  assign hit0_qual     = entry_vld & entry_hit0;
  assign hit1_qual     = entry_vld & entry_hit1;
  assign utlb_hit0_sel = hit0_qual & (~hit0_qual + 1'b1);
  assign utlb_hit1_sel = hit1_qual & (~hit1_qual + 1'b1);
  assign utlb_hit0     = |hit0_qual;
  assign utlb_hit1     = |hit1_qual;

  // Port 0 wins; a port-1 miss to the same 1 GiB page is covered by the
  // port-0 fill, any other port-1 miss simply retries once busy drops.
  assign miss0    = lsu_req0_vld & ~utlb_hit0;
  assign miss1    = lsu_req1_vld & ~utlb_hit1;
  assign any_miss = miss0 | miss1;
  assign miss_vpn = miss0 ? utlb_req_vpn0 : utlb_req_vpn1;

  assign flush_now = regs_utlb_clr | tlboper_utlb_clr | tlboper_utlb_inv_va_req;
  assign repl_clr  = regs_utlb_clr | tlboper_utlb_clr;

  // Free entries are used before evicting; scanning downward leaves the lowest.
  always_comb begin
    victim_idx = repl_victim;
    for (int i = ENTRY_NUM - 1; i >= 0; i--)
      if (!entry_vld[i]) victim_idx = IDX_W'(i);
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    refill_load = 1'b0;
    refill_req  = 1'b0;
    refill_fill = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_miss) begin
          refill_load = 1'b1;
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        refill_req = 1'b1;
        if (jtlb_if.jtlb_utlb_ack) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (jtlb_if.jtlb_utlb_resp_vld) begin
          state_d     = ST_IDLE;
          refill_fill = jtlb_if.jtlb_utlb_resp_huge & ~jtlb_if.jtlb_utlb_resp_fault &
                        ~abort_q & ~flush_now;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge utlb_entry_clk or negedge cpurst_b) begin
    if (!cpurst_b) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_ff @(posedge utlb_entry_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      refill_vpn <= '0;
      refill_idx <= '0;
    end else if (refill_load) begin
      refill_vpn <= miss_vpn;
      refill_idx <= victim_idx;
    end
  end

  // An in-flight request is never withdrawn; a flush only poisons its response.
  always_ff @(posedge utlb_entry_clk or negedge cpurst_b) begin
    if (!cpurst_b)                              abort_q <= 1'b0;
    else if (refill_load)                       abort_q <= 1'b0;
    else if ((state_q != ST_IDLE) && flush_now) abort_q <= 1'b1;
  end

  always_comb begin
    utlb_entry_upd = '0;
    for (int i = 0; i < ENTRY_NUM; i++)
      utlb_entry_upd[i] = refill_fill & (refill_idx == IDX_W'(i));
  end

  assign jtlb_if.utlb_jtlb_req = refill_req;
  assign jtlb_if.utlb_jtlb_vpn = refill_vpn;
  assign utlb_refill_busy      = (state_q != ST_IDLE);

  ct_mmu_dutlb_huge_repl #(.ENTRY_NUM(ENTRY_NUM)) u_repl (
    .utlb_entry_clk (utlb_entry_clk),
    .cpurst_b       (cpurst_b),
    .repl_clr       (repl_clr),
    .touch0         (utlb_hit0_sel),
    .touch1         (utlb_hit1_sel),
    .touch_upd      (utlb_entry_upd),
    .victim_idx     (repl_victim)
  );

endmodule

// File: tb/tb_ct_mmu_dutlb_huge_ctrl.sv
// Bench for ct_mmu_dutlb_huge_ctrl: directed scenarios, then random traffic
// compared every cycle against a transaction-level reference model.
module tb_ct_mmu_dutlb_huge_ctrl;
  import ct_mmu_dutlb_huge_ctrl_pkg::*;

  localparam int N   = 4;
  localparam int LVL = $clog2(N);

  logic                 utlb_entry_clk = 1'b0;
  logic                 cpurst_b;
  logic                 lsu_req0_vld, lsu_req1_vld;
  logic [VPN_WIDTH-1:0] utlb_req_vpn0, utlb_req_vpn1;
  logic [N-1:0]         entry_vld, entry_hit0, entry_hit1;
  logic                 regs_utlb_clr, tlboper_utlb_clr, tlboper_utlb_inv_va_req;
  logic [N-1:0]         utlb_hit0_sel, utlb_hit1_sel, utlb_entry_upd;
  logic                 utlb_hit0, utlb_hit1, utlb_refill_busy;

  ct_mmu_dutlb_huge_ctrl_if jif();

  ct_mmu_dutlb_huge_ctrl #(.ENTRY_NUM(N)) dut (
    .utlb_entry_clk          (utlb_entry_clk),
    .cpurst_b                (cpurst_b),
    .lsu_req0_vld            (lsu_req0_vld),
    .lsu_req1_vld            (lsu_req1_vld),
    .utlb_req_vpn0           (utlb_req_vpn0),
    .utlb_req_vpn1           (utlb_req_vpn1),
    .entry_vld               (entry_vld),
    .entry_hit0              (entry_hit0),
    .entry_hit1              (entry_hit1),
    .regs_utlb_clr           (regs_utlb_clr),
    .tlboper_utlb_clr        (tlboper_utlb_clr),
    .tlboper_utlb_inv_va_req (tlboper_utlb_inv_va_req),
    .jtlb_if                 (jif),
    .utlb_hit0_sel           (utlb_hit0_sel),
    .utlb_hit1_sel           (utlb_hit1_sel),
    .utlb_hit0               (utlb_hit0),
    .utlb_hit1               (utlb_hit1),
    .utlb_entry_upd          (utlb_entry_upd),
    .utlb_refill_busy        (utlb_refill_busy)
  );

  always #5 utlb_entry_clk = ~utlb_entry_clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: outstanding-refill bookkeeping plus replacement history.
  int                   m_phase;   // 0 none outstanding, 1 awaiting ack, 2 awaiting response
  logic [VPN_WIDTH-1:0] m_vpn;
  int                   m_idx;
  bit                   m_abort;
  int                   m_rr;
  bit                   m_tree [N-1];
  logic [N-1:0]         vld_state;
  logic [N-1:0]         e_upd;

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++)
      if (v[i]) return i;
    return -1;
  endfunction

  function automatic int tree_victim();
    int n = 0, v = 0, b;
    for (int l = 0; l < LVL; l++) begin
      b = int'(m_tree[n]);
      v = v * 2 + b;
      n = 2 * n + 1 + b;
    end
    return v;
  endfunction

  task automatic tree_touch(input int idx);
    int n = 0, b;
    for (int l = LVL - 1; l >= 0; l--) begin
      b = (idx >> l) & 1;
      m_tree[n] = (b == 0);
      n = 2 * n + 1 + b;
    end
  endtask

  function automatic int model_victim();
    int f = lowest(~entry_vld);
    if (f >= 0) return f;
`ifdef CT_MMU_DUTLB_HUGE_PLRU_EN
    return tree_victim();
`else
    return m_rr;
`endif
  endfunction

  task automatic idle_inputs();
    lsu_req0_vld = 1'b0; lsu_req1_vld = 1'b0;
    utlb_req_vpn0 = '0;  utlb_req_vpn1 = '0;
    entry_hit0 = '0;     entry_hit1 = '0;
    regs_utlb_clr = 1'b0; tlboper_utlb_clr = 1'b0; tlboper_utlb_inv_va_req = 1'b0;
    jif.jtlb_utlb_ack = 1'b0; jif.jtlb_utlb_resp_vld = 1'b0;
    jif.jtlb_utlb_resp_huge = 1'b0; jif.jtlb_utlb_resp_fault = 1'b0;
  endtask

  // Compare every output against the model for the inputs of this cycle.
  task automatic settle();
    int   l0, l1, ph;
    logic flush;
    #1;
    l0    = lowest(entry_vld & entry_hit0);
    l1    = lowest(entry_vld & entry_hit1);
    ph    = cpurst_b ? m_phase : 0;
    flush = regs_utlb_clr | tlboper_utlb_clr | tlboper_utlb_inv_va_req;
    e_upd = '0;
    if (ph == 2 && jif.jtlb_utlb_resp_vld && jif.jtlb_utlb_resp_huge &&
        !jif.jtlb_utlb_resp_fault && !m_abort && !flush)
      e_upd = N'(1 << m_idx);
    check("hit0_sel", 32'(utlb_hit0_sel), (l0 < 0) ? 32'd0 : 32'(1 << l0));
    check("hit1_sel", 32'(utlb_hit1_sel), (l1 < 0) ? 32'd0 : 32'(1 << l1));
    check("hit0", 32'(utlb_hit0), 32'(l0 >= 0));
    check("hit1", 32'(utlb_hit1), 32'(l1 >= 0));
    check("req", 32'(jif.utlb_jtlb_req), 32'(ph == 1));
    check("vpn", 32'(jif.utlb_jtlb_vpn), cpurst_b ? 32'(m_vpn) : 32'd0);
    check("upd", 32'(utlb_entry_upd), 32'(e_upd));
    check("busy", 32'(utlb_refill_busy), 32'(ph != 0));
  endtask

  // Apply the clock edge to the model, then move to the next falling edge.
  task automatic advance();
    int   l0, l1, vic;
    logic flush, clr, miss0, miss1;
    if (!cpurst_b) begin
      m_phase = 0; m_vpn = '0; m_idx = 0; m_abort = 0; m_rr = 0;
      foreach (m_tree[i]) m_tree[i] = 0;
    end else begin
      l0    = lowest(entry_vld & entry_hit0);
      l1    = lowest(entry_vld & entry_hit1);
      flush = regs_utlb_clr | tlboper_utlb_clr | tlboper_utlb_inv_va_req;
      clr   = regs_utlb_clr | tlboper_utlb_clr;
      miss0 = lsu_req0_vld && l0 < 0;
      miss1 = lsu_req1_vld && l1 < 0;
      vic   = model_victim();
      case (m_phase)
        0: if (miss0 || miss1) begin
             m_vpn = miss0 ? utlb_req_vpn0 : utlb_req_vpn1;
             m_idx = vic; m_abort = 0; m_phase = 1;
           end
        1: begin
             if (flush) m_abort = 1;
             if (jif.jtlb_utlb_ack) m_phase = 2;
           end
        default: begin
             if (flush) m_abort = 1;
             if (jif.jtlb_utlb_resp_vld) m_phase = 0;
           end
      endcase
      if (clr) begin
        m_rr = 0;
        foreach (m_tree[i]) m_tree[i] = 0;
      end else begin
        if (e_upd != '0) m_rr = (m_rr + 1) % N;
        if (l0 >= 0) tree_touch(l0);
        if (l1 >= 0) tree_touch(l1);
        if (e_upd != '0) tree_touch(lowest(e_upd));
      end
      vld_state = vld_state | e_upd;
      if (clr) vld_state = '0;
    end
    @(negedge utlb_entry_clk);
    entry_vld = vld_state;
  endtask

  task automatic refill(input string tag, input logic [VPN_WIDTH-1:0] v, input logic huge,
                        input logic fault, input logic flush_wait, input logic [N-1:0] exp_upd);
    idle_inputs(); lsu_req0_vld = 1'b1; utlb_req_vpn0 = v;
    settle(); advance();
    idle_inputs();
    settle(); check({tag, "_req"}, 32'(jif.utlb_jtlb_req), 32'd1);
    check({tag, "_vpn"}, 32'(jif.utlb_jtlb_vpn), 32'(v));
    advance();
    jif.jtlb_utlb_ack = 1'b1;
    settle(); advance();
    idle_inputs();
    if (flush_wait) begin
      tlboper_utlb_inv_va_req = 1'b1;
      settle(); advance();
      idle_inputs();
    end
    jif.jtlb_utlb_resp_vld = 1'b1; jif.jtlb_utlb_resp_huge = huge; jif.jtlb_utlb_resp_fault = fault;
    settle(); check({tag, "_upd"}, 32'(utlb_entry_upd), 32'(exp_upd));
    advance();
    idle_inputs();
    settle(); check({tag, "_busy"}, 32'(utlb_refill_busy), 32'd0);
    advance();
  endtask

  logic [VPN_WIDTH-1:0] va, vb;
  int                   exp_vic;

  initial begin
    idle_inputs();
    vld_state = '0; entry_vld = '0; e_upd = '0;
    cpurst_b  = 1'b0;
    #2;
    settle();
    check("rst_busy", 32'(utlb_refill_busy), 32'd0);
    advance();
    cpurst_b = 1'b1;

    // Cold miss with the documented timeline.
    lsu_req0_vld = 1'b1; utlb_req_vpn0 = 27'h1234567;
    settle(); check("cold_req_T", 32'(jif.utlb_jtlb_req), 32'd0); advance();
    idle_inputs();
    settle(); check("cold_req_T1", 32'(jif.utlb_jtlb_req), 32'd1);
    check("cold_vpn", 32'(jif.utlb_jtlb_vpn), 32'h1234567); advance();
    settle(); advance();
    jif.jtlb_utlb_ack = 1'b1;
    settle(); check("cold_req_T3", 32'(jif.utlb_jtlb_req), 32'd1); advance();
    idle_inputs();
    settle(); check("cold_wait_req", 32'(jif.utlb_jtlb_req), 32'd0);
    check("cold_wait_busy", 32'(utlb_refill_busy), 32'd1); advance();
    jif.jtlb_utlb_resp_vld = 1'b1; jif.jtlb_utlb_resp_huge = 1'b1;
    settle(); check("cold_upd", 32'(utlb_entry_upd), 32'h1); advance();
    idle_inputs();
    settle(); check("cold_busy_T6", 32'(utlb_refill_busy), 32'd0); advance();

    // Dual-port miss on one 1 GiB page: one request carrying the port-0 VPN.
    va = {9'h0AB, 18'h00001}; vb = {9'h0AB, 18'h3FFFF};
    lsu_req0_vld = 1'b1; utlb_req_vpn0 = va; lsu_req1_vld = 1'b1; utlb_req_vpn1 = vb;
    settle(); advance();
    idle_inputs();
    settle(); check("dual_vpn", 32'(jif.utlb_jtlb_vpn), 32'(va)); advance();
    jif.jtlb_utlb_ack = 1'b1; settle(); advance();
    idle_inputs();
    jif.jtlb_utlb_resp_vld = 1'b1; jif.jtlb_utlb_resp_huge = 1'b1;
    settle(); check("dual_upd", 32'(utlb_entry_upd), 32'h2); advance();
    idle_inputs();
    lsu_req0_vld = 1'b1; utlb_req_vpn0 = va; entry_hit0 = 4'b0010;
    lsu_req1_vld = 1'b1; utlb_req_vpn1 = vb; entry_hit1 = 4'b0010;
    settle(); check("dual_hit1", 32'(utlb_hit1), 32'd1); advance();
    idle_inputs();
    settle(); check("dual_single_req", 32'(jif.utlb_jtlb_req), 32'd0); advance();

    refill("fault", 27'h0400000, 1'b1, 1'b1, 1'b0, '0);
    refill("nohuge", 27'h0800000, 1'b0, 1'b0, 1'b0, '0);
    refill("flush_wait", 27'h0C00000, 1'b1, 1'b0, 1'b1, '0);

    // Reset while a request is outstanding; a late response must be ignored.
    lsu_req0_vld = 1'b1; utlb_req_vpn0 = 27'h1000000;
    settle(); advance();
    idle_inputs();
    settle(); check("rreq_req", 32'(jif.utlb_jtlb_req), 32'd1); advance();
    cpurst_b = 1'b0;
    settle(); check("rreq_req_low", 32'(jif.utlb_jtlb_req), 32'd0);
    check("rreq_busy", 32'(utlb_refill_busy), 32'd0); advance();
    cpurst_b = 1'b1;
    jif.jtlb_utlb_resp_vld = 1'b1; jif.jtlb_utlb_resp_huge = 1'b1;
    settle(); check("rreq_stray_upd", 32'(utlb_entry_upd), 32'd0); advance();
    idle_inputs();

    // Full array: hits on 0,1,2 then a miss picks the replacement victim.
    vld_state = '1; entry_vld = '1;
    for (int i = 0; i < 3; i++) begin
      lsu_req0_vld = 1'b1; entry_hit0 = N'(1 << i);
      settle(); advance();
    end
    idle_inputs();
`ifdef CT_MMU_DUTLB_HUGE_PLRU_EN
    exp_vic = tree_victim();
`else
    exp_vic = 0;
`endif
    refill("full", 27'h1400000, 1'b1, 1'b0, 1'b0, N'(1 << exp_vic));

    // Random traffic against the model.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      idle_inputs();
      cpurst_b = ($urandom_range(0, 399) != 0);
      lsu_req0_vld = ($urandom_range(0, 2) == 0);
      lsu_req1_vld = ($urandom_range(0, 2) == 0);
      utlb_req_vpn0 = {9'($urandom_range(0, 3)), 18'($urandom)};
      utlb_req_vpn1 = {9'($urandom_range(0, 3)), 18'($urandom)};
      entry_hit0 = N'($urandom) & N'($urandom);
      entry_hit1 = N'($urandom) & N'($urandom);
      regs_utlb_clr           = ($urandom_range(0, 59) == 0);
      tlboper_utlb_clr        = ($urandom_range(0, 59) == 0);
      tlboper_utlb_inv_va_req = ($urandom_range(0, 29) == 0);
      if (m_phase == 1) jif.jtlb_utlb_ack = ($urandom_range(0, 2) == 0);
      if ((m_phase == 2 && $urandom_range(0, 2) == 0) ||
          (m_phase == 0 && $urandom_range(0, 19) == 0)) begin
        jif.jtlb_utlb_resp_vld   = 1'b1;
        jif.jtlb_utlb_resp_huge  = ($urandom_range(0, 3) != 0);
        jif.jtlb_utlb_resp_fault = ($urandom_range(0, 5) == 0);
      end
      if ($urandom_range(0, 19) == 0) vld_state[$urandom_range(0, N - 1)] = 1'b0;
      if ($urandom_range(0, 9) == 0)  vld_state = '1;
      entry_vld = vld_state;
      settle(); advance();
    end

    cpurst_b = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
